// File: rtl/cmd_uart_pkg.sv
// rtl/cmd_uart_pkg.sv - shared state encodings and frame constants for the command UART
//
// Purpose : state encodings for the RX, TX and command-assembly FSMs and the
//           serial frame length, shared by cmd_uart_rx and cmd_uart_wrapper.
// Ports   : none (package)
package cmd_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    SHIFT   = 1'b1
  } tx_state_t;

  typedef enum logic [0:0] {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } asm_state_t;

  // start bit + 8 data bits + stop bit
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/cmd_uart_if.sv
// rtl/cmd_uart_if.sv - command/response handshake between command processor and UART endpoint
//
// Purpose : bundles the parallel side of the command link.
// Signals : cmd[15:0]    assembled command {first byte, second byte}
//           cmd_rdy      sticky, new command valid
//           clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//           resp[7:0]    response byte, sampled on trmt
//           trmt         1-cycle pulse, start response transmission
//           tx_done      sticky, response byte fully sent
// Modports: master = command processor, slave = cmd_uart_wrapper
interface cmd_uart_if;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  modport master (
    output clr_cmd_rdy,
    output resp,
    output trmt,
    input  cmd,
    input  cmd_rdy,
    input  tx_done
  );

  modport slave (
    input  clr_cmd_rdy,
    input  resp,
    input  trmt,
    output cmd,
    output cmd_rdy,
    output tx_done
  );

endinterface

// File: rtl/cmd_uart_rx.sv
// rtl/cmd_uart_rx.sv - 8N1 serial byte receiver with input synchronizer
//
// Purpose : double-flops the asynchronous serial input, detects the start
//           bit, samples each bit at mid-period and shifts in 8 data bits
//           LSB first. A byte is only announced when its stop bit reads 1.
// Ports   : clk         system clock
//           rst         asynchronous active-high reset
//           i_rx        serial input, idles high
//           o_byte      last received byte (valid while o_byte_rdy is high)
//           o_byte_rdy  1-cycle pulse in the cycle after the stop-bit sample
module cmd_uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_rdy
);

  import cmd_uart_pkg::*;

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_rdy;

  // Counter is loaded with N and the sample is taken on the edge where it
  // reads 1, i.e. exactly N cycles after the load.
  logic w_tick;
  assign w_tick = (r_cnt == C_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_rdy <= 1'b0;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_sync  <= r_rx_meta;
      r_byte_rdy <= 1'b0;

      if (r_state == S_IDLE) begin
        if (!r_rx_sync) begin
          r_cnt   <= C_HALF;
          r_state <= S_START;
        end
      end else if (!w_tick) begin
        r_cnt <= r_cnt - C_ONE;
      end else begin
        r_cnt <= C_FULL;
        case (r_state)
          S_START: begin
            // still high at mid start bit: it was a glitch
            if (r_rx_sync) begin
              r_state <= S_IDLE;
            end else begin
              r_bit_cnt <= '0;
              r_state   <= S_DATA;
            end
          end
          S_DATA: begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end
          S_STOP: begin
            // a low stop bit is a framing error; the byte is silently dropped
            r_byte_rdy <= r_rx_sync;
            r_state    <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_byte     = r_shift;
  assign o_byte_rdy = r_byte_rdy;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// rtl/cmd_uart_wrapper.sv - DUT-side endpoint of the remote command link
//
// Purpose : receives serial byte pairs and presents them as 16-bit commands
//           (high byte first) with a sticky ready flag; serializes one
//           response byte per trmt back onto the serial line.
// Ports   : clk      system clock
//           rst      asynchronous active-high reset
//           RX       serial input, idles high, asynchronous to clk
//           TX       serial output, idles high
//           cmd_bus  command/response handshake (cmd_uart_if.slave)
module cmd_uart_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  cmd_uart_if.slave  cmd_bus
);

  import cmd_uart_pkg::*;

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  localparam logic [0:0] T_IDLE  = TX_IDLE;
  localparam logic [0:0] T_SHIFT = SHIFT;

  localparam logic [0:0] A_WAIT_HIGH = WAIT_HIGH;
  localparam logic [0:0] A_WAIT_LOW  = WAIT_LOW;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [7:0] w_byte;
  logic       w_byte_rdy;

  cmd_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .i_rx       (RX),
    .o_byte     (w_byte),
    .o_byte_rdy (w_byte_rdy)
  );

  // ---------------------------------------------------------------------------
  // Command assembly: pairs bytes high-then-low. There is no timeout, so a
  // lost byte keeps the pairing skewed until reset.
  // ---------------------------------------------------------------------------
  logic [0:0]  r_asm_state;
  logic [7:0]  r_high;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_asm_state <= A_WAIT_HIGH;
      r_high      <= '0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
    end else if (w_byte_rdy) begin
      // byte arrival has priority over the acknowledge, so a set coinciding
      // with clr_cmd_rdy is not lost
      if (r_asm_state == A_WAIT_HIGH) begin
        r_high      <= w_byte;
        r_cmd_rdy   <= 1'b0;
        r_asm_state <= A_WAIT_LOW;
      end else begin
        r_cmd       <= {r_high, w_byte};
        r_cmd_rdy   <= 1'b1;
        r_asm_state <= A_WAIT_HIGH;
      end
    end else if (cmd_bus.clr_cmd_rdy) begin
      r_cmd_rdy <= 1'b0;
    end
  end

  assign cmd_bus.cmd     = r_cmd;
  assign cmd_bus.cmd_rdy = r_cmd_rdy;

  // ---------------------------------------------------------------------------
  // Response serializer. The start bit goes out on the trmt edge itself; the
  // shift register then holds the remaining data bits plus the stop bit.
  // ---------------------------------------------------------------------------
  logic [0:0]       r_tx_state;
  logic [8:0]       r_tx_shift;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [BIT_W-1:0] r_tx_bit;
  logic             r_tx;
  logic             r_tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (cmd_bus.trmt) begin
            r_tx       <= 1'b0;
            r_tx_shift <= {1'b1, cmd_bus.resp};
            r_tx_cnt   <= C_FULL;
            r_tx_bit   <= '0;
            r_tx_done  <= 1'b0;
            r_tx_state <= T_SHIFT;
          end
        end
        T_SHIFT: begin
          // trmt is ignored here; resp was captured at frame start
          if (r_tx_cnt != C_ONE) begin
            r_tx_cnt <= r_tx_cnt - C_ONE;
          end else if (r_tx_bit == LAST_BIT) begin
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b1;
            r_tx_state <= T_IDLE;
          end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
            r_tx_bit   <= r_tx_bit + BIT_ONE;
            r_tx_cnt   <= C_FULL;
          end
        end
        default: begin
          r_tx_state <= T_IDLE;
        end
      endcase
    end
  end

  assign TX              = r_tx;
  assign cmd_bus.tx_done = r_tx_done;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb/tb_cmd_uart_wrapper.sv - directed self-checking bench for cmd_uart_wrapper
module tb_cmd_uart_wrapper;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic RX;
  logic TX;

  cmd_uart_if cmd_bus ();

  cmd_uart_wrapper #(
    .BAUD_DIV (BD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .TX      (TX),
    .cmd_bus (cmd_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc      = 0;
  int   last_t0  = 0;
  int   rise_cyc = -1;
  int   brdy_cyc = -1;
  int   n_brdy   = 0;
  int   n0;
  logic prev_rdy = 1'b0;

  logic exp_tx [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dut.w_byte_rdy) begin
      n_brdy++;
      brdy_cyc = cyc;
    end
    if (cmd_bus.cmd_rdy && !prev_rdy) rise_cyc = cyc;
    prev_rdy = cmd_bus.cmd_rdy;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame; last_t0 is the cycle count at the edge before RX falls.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    @(posedge clk);
    #1;
    last_t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    RX = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst                 = 1'b1;
    RX                  = 1'b1;
    cmd_bus.trmt        = 1'b0;
    cmd_bus.resp        = 8'h00;
    cmd_bus.clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check_val("reset_tx",      TX,              1);
    check_val("reset_cmd",     cmd_bus.cmd,     0);
    check_val("reset_cmd_rdy", cmd_bus.cmd_rdy, 0);
    check_val("reset_tx_done", cmd_bus.tx_done, 0);
    idle(4);

    // A5, 3C -> A53C with exact latency from RX fall
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check_val("rdy_after_high", cmd_bus.cmd_rdy, 0);
    rise_cyc = -1;
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    check_val("cmd_a53c",     cmd_bus.cmd,        16'hA53C);
    check_val("rdy_a53c",     cmd_bus.cmd_rdy,    1);
    check_val("brdy_latency", brdy_cyc - last_t0, 155);
    check_val("rdy_latency",  rise_cyc - last_t0, 156);

    // acknowledge
    @(posedge clk);
    #1;
    cmd_bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    check_val("rdy_before_clr", cmd_bus.cmd_rdy, 1);
    @(posedge clk);
    #1;
    cmd_bus.clr_cmd_rdy = 1'b0;
    check_val("rdy_after_clr", cmd_bus.cmd_rdy, 0);
    check_val("cmd_after_clr", cmd_bus.cmd,     16'hA53C);

    send_byte(8'h12, 1'b1);
    @(negedge clk);
    check_val("rdy_after_12", cmd_bus.cmd_rdy, 0);
    check_val("cmd_after_12", cmd_bus.cmd,     16'hA53C);

    // framing error between 12 and 34
    n0 = n_brdy;
    send_byte(8'h55, 1'b0);
    idle(32);
    check_val("frame_err_no_byte", n_brdy, n0);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    check_val("cmd_1234",        cmd_bus.cmd,     16'h1234);
    check_val("rdy_1234",        cmd_bus.cmd_rdy, 1);
    check_val("brdy_count_1234", n_brdy,          n0 + 1);

    // response C3, with an ignored trmt inside the frame
    @(posedge clk);
    #1;
    cmd_bus.resp = 8'hC3;
    cmd_bus.trmt = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 161; c++) begin
      if (c == 50) begin
        cmd_bus.trmt = 1'b1;
        cmd_bus.resp = 8'h00;
      end else begin
        cmd_bus.trmt = 1'b0;
      end
      @(negedge clk);
      if (c <= 160 && (((c - 1) % BD) == 0 || ((c - 1) % BD) == BD - 1))
        check_val($sformatf("tx_bit%0d_c%0d", (c - 1) / BD, c), TX, exp_tx[(c - 1) / BD]);
      if (c == 160) check_val("tx_done_c160", cmd_bus.tx_done, 0);
      if (c == 161) begin
        check_val("tx_done_c161", cmd_bus.tx_done, 1);
        check_val("tx_idle_c161", TX,              1);
      end
      @(posedge clk);
      #1;
    end
    idle(20);
    check_val("tx_done_sticky", cmd_bus.tx_done, 1);
    check_val("tx_idle_after",  TX,              1);

    // next high byte clears cmd_rdy
    send_byte(8'hFF, 1'b1);
    @(negedge clk);
    check_val("rdy_cleared_by_ff", cmd_bus.cmd_rdy, 0);
    check_val("cmd_hold_1234",     cmd_bus.cmd,     16'h1234);

    // reset mid TX frame and with a partial command pending
    @(posedge clk);
    #1;
    cmd_bus.resp = 8'h00;
    cmd_bus.trmt = 1'b1;
    @(posedge clk);
    #1;
    cmd_bus.trmt = 1'b0;
    check_val("tx_done_cleared_by_trmt", cmd_bus.tx_done, 0);
    idle(40);
    check_val("tx_low_before_rst", TX, 0);
    rst = 1'b1;
    #1;
    check_val("rst_tx_high",  TX,              1);
    check_val("rst_tx_done",  cmd_bus.tx_done, 0);
    check_val("rst_cmd",      cmd_bus.cmd,     0);
    check_val("rst_cmd_rdy",  cmd_bus.cmd_rdy, 0);
    idle(2);
    rst = 1'b0;
    idle(4);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk);
    check_val("cmd_1234_after_rst", cmd_bus.cmd,     16'h1234);
    check_val("rdy_1234_after_rst", cmd_bus.cmd_rdy, 1);

    // set wins over a simultaneous clear
    send_byte(8'h56, 1'b1);
    @(negedge clk);
    check_val("rdy_after_56", cmd_bus.cmd_rdy, 0);
    @(posedge clk);
    #1;
    cmd_bus.clr_cmd_rdy = 1'b1;
    rise_cyc = -1;
    send_byte(8'h78, 1'b1);
    @(negedge clk);
    check_val("set_wins_rise", rise_cyc - last_t0, 156);
    check_val("cmd_5678",      cmd_bus.cmd,        16'h5678);
    check_val("rdy_held_clr",  cmd_bus.cmd_rdy,    0);
    @(posedge clk);
    #1;
    cmd_bus.clr_cmd_rdy = 1'b0;

    // 6-cycle low glitch on RX
    n0 = n_brdy;
    @(posedge clk);
    #1;
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_val("glitch_start_seen", dut.u_rx.r_state, 1);
    repeat (2) @(posedge clk);
    #1;
    RX = 1'b1;
    idle(40);
    check_val("glitch_no_byte", n_brdy,           n0);
    check_val("glitch_idle",    dut.u_rx.r_state, 0);
    check_val("glitch_cmd",     cmd_bus.cmd,      16'h5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_uart_wrapper.md
# cmd_uart_wrapper

DUT-side endpoint of the remote command link. It receives 8N1 serial bytes, assembles each pair into a 16-bit command (high byte first), and presents it with a sticky ready flag to the command processor. It also serializes an 8-bit response byte back to the remote side. It is the receiving peer of the two-byte command transmitter on the remote end.

## Interface
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200 baud); must be ≥ 4.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- RX  in  1  serial input, idles high, asynchronous to clk
- TX  out  1  serial output, idles high
- cmd  out  16  assembled command, {first byte, second byte}
- cmd_rdy  out  1  sticky: new command valid
- clr_cmd_rdy  in  1  consumer acknowledge, clears cmd_rdy
- resp  in  8  response byte, sampled on trmt
- trmt  in  1  start response transmission (1-cycle pulse)
- tx_done  out  1  sticky: response byte fully sent

## Operation
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_done=0; all FSMs in idle; assembly FSM in WAIT_HIGH.
- RX path: RX is double-flopped before use. RX FSM states are IDLE, START, DATA, STOP.
  - IDLE: on synced RX=0, load baud counter with BAUD_DIV/2 (floor) → START.
  - Each counter expiry samples the bit and reloads BAUD_DIV.
  - START: a sample of 1 is a false start → IDLE. A sample of 0 → DATA.
  - DATA: 8 samples shifted in LSB first → STOP.
  - STOP: a sample of 1 pulses byte_rdy for one cycle. A sample of 0 is a framing error: the byte is discarded and no pulse is issued. Either case → IDLE.
- Assembly FSM states are WAIT_HIGH and WAIT_LOW.
  - WAIT_HIGH + byte_rdy: latch byte into the high register; clear cmd_rdy → WAIT_LOW.
  - WAIT_LOW + byte_rdy: cmd ← {high, byte}; set cmd_rdy → WAIT_HIGH.
  - There is no inter-byte timeout. Alignment is recovered only by rst.
- cmd_rdy: set as above; cleared by clr_cmd_rdy or by the next high byte. If set and clear occur in the same cycle, set wins. cmd holds its value until the next completed pair.
- TX path: TX FSM states are IDLE and SHIFT, with a 10-bit frame: start 0, resp[0..7], stop 1.
  - trmt in IDLE loads resp, clears tx_done → SHIFT.
  - trmt during SHIFT is ignored; resp is not resampled.
  - After the 10th bit period, set tx_done → IDLE. tx_done stays high until the next accepted trmt.
- RX and TX are fully independent; full duplex operation is required.

## Timing
- Falling edge on RX to START entry: 2 cycles of synchronizer plus 1 cycle of detection.
- Bit samples are taken BAUD_DIV/2 + k·BAUD_DIV cycles after START entry, k=0..9.
- byte_rdy pulses in the cycle of the stop-bit sample. cmd and cmd_rdy update on the following edge, i.e. 1 cycle latency.
- TX start bit drives TX the cycle after trmt. Each bit is held exactly BAUD_DIV cycles. tx_done rises 10·BAUD_DIV cycles after TX first goes low.
- rst mid-frame: RX byte lost, a partial command is discarded, TX returns high immediately, tx_done=0.
- An RX low glitch shorter than BAUD_DIV/2 must not produce a byte.

## Structure
- Package cmd_uart_pkg holds:
  - enums rx_state_t {IDLE, START, DATA, STOP}
  - tx_state_t {TX_IDLE, SHIFT}
  - asm_state_t {WAIT_HIGH, WAIT_LOW}
  - localparam FRAME_BITS=10
- One sub-module, cmd_uart_rx, contains the synchronizer, RX FSM, baud counter and shift register, and outputs byte[7:0] and byte_rdy.
- The TX serializer and assembly FSM live in the top module.

## Test plan
All scenarios use BAUD_DIV=16.
- Send bytes 0xA5 then 0x3C. Expect cmd=16'hA53C; cmd_rdy rises 1 cycle after the second stop-bit sample.
- Pulse clr_cmd_rdy. Expect cmd_rdy=0 the next cycle, cmd still 16'hA53C. Then send 0x12 and observe cmd_rdy=0 from the first byte's completion.
- resp=8'hC3, pulse trmt. Expect TX sequence 0,1,1,0,0,0,0,1,1,1, each bit 16 cycles; tx_done=1 at 160 cycles. A second trmt at cycle 50 has no effect.
- Send a byte with stop bit 0 between 0x12 and 0x34. Expect the byte discarded and cmd=16'h1234.
- Assert rst after the high byte 0xFF, then send 0x12, 0x34. Expect cmd=16'h1234 and cmd_rdy=1.
- Pulse RX low for 6 cycles. Expect no byte_rdy and the FSM back in IDLE.
